// File: rtl/fifo_rd_pkg.sv
// Shared constants and index helpers for the FIFO read-side stream.
// Latency: n/a. Backpressure: n/a.
package fifo_rd_pkg;

    localparam int DEF_BUF_DEPTH = 2;

    // Wide enough to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic int unsigned idx_inc(input int unsigned idx, input int unsigned depth);
        return (idx >= depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Prefetch buffer: BUF_DEPTH words captured from the FIFO memory, head shown directly.
// Latency: push visible at head_dat/count one cycle later. Backpressure: caller must not push when full.
// Storage, indices and occupancy count all reset to zero.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int  WIDTH     = 16,
    parameter int  BUF_DEPTH = DEF_BUF_DEPTH,
    localparam int CW        = cnt_width(BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);

    localparam int IW = idx_width(BUF_DEPTH);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic [CW-1:0]    count_next;

    assign count_next = count + CW'(push) - CW'(pop);
    assign head_dat   = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            assert (!(push && !pop && count == CW'(BUF_DEPTH)));
            assert (!(pop && !push && count == '0));
            if (push) begin
                mem[wr_idx] <= push_dat;
                wr_idx      <= IW'(idx_inc(32'(wr_idx), BUF_DEPTH));
            end
            if (pop) begin
                rd_idx <= IW'(idx_inc(32'(rd_idx), BUF_DEPTH));
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// FWFT valid/ready stream from the async FIFO read port; optional rd_word_cnt via FIFO_RD_STREAM_WORD_CNT_EN.
// Latency: rd_en -> m_valid in 2 rd_clk cycles; 1 word/cycle sustained with BUF_DEPTH >= 2.
// Backpressure: reads stop once buffered + in-flight words reach BUF_DEPTH; m_valid/m_data hold until taken.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
    ,
    output logic [31:0]      rd_word_cnt
`endif
);

    localparam int CW = cnt_width(BUF_DEPTH);
    localparam int OW = CW + 1;

    logic          inflight;
    logic          pop;
    logic [CW-1:0] count;
    logic [OW-1:0] occupancy;

    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;

    // Counts the word leaving this cycle as free space so a full buffer keeps streaming.
    assign occupancy = {1'b0, count} + OW'(inflight) - OW'(pop);
    assign rd_en     = rd_rst && !empty && (occupancy < OW'(BUF_DEPTH));

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
        end
    end

    fifo_rd_skid_buf #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_skid_buf (
        .clk      (rd_clk),
        .rst_n    (rd_rst),
        .push     (inflight),
        .push_dat (fifo_rdata),
        .pop      (pop),
        .head_dat (m_data),
        .count    (count)
    );

`ifdef FIFO_RD_STREAM_WORD_CNT_EN
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            rd_word_cnt <= '0;
        end else if (pop) begin
            rd_word_cnt <= rd_word_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO memory model feeding the DUT, scoreboard on the stream side.
module tb_fifo_rd_stream;

    localparam int WIDTH = 16;

    logic             rd_clk   = 1'b0;
    logic             rd_rst   = 1'b0;
    logic             m_ready  = 1'b0;
    logic             flush_en = 1'b0;
    logic             empty;
    logic [WIDTH-1:0] fifo_rdata = '0;
    logic             rd_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
    logic [31:0]      rd_word_cnt;
`endif

    logic [WIDTH-1:0] fmem [256];
    logic [7:0]       wr_ptr = 8'd0;
    logic [7:0]       rd_ptr = 8'd0;
    logic [WIDTH-1:0] exp_q [$];

    int               n_total = 0;
    int               n_bad   = 0;
    int               n_rden  = 0;
    logic             s_rden;
    logic             s_valid;
    logic [WIDTH-1:0] s_data;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_stream #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (2)
    ) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .empty      (empty),
        .fifo_rdata (fifo_rdata),
        .rd_en      (rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
        ,
        .rd_word_cnt(rd_word_cnt)
`endif
    );

    // FIFO memory: registered data_out, read side flushed with rd_rst when requested.
    assign empty = (rd_ptr == wr_ptr);

    always @(posedge rd_clk) begin
        if (!rd_rst) begin
            if (flush_en) rd_ptr <= wr_ptr;
        end else if (rd_en && !empty) begin
            fifo_rdata <= fmem[rd_ptr];
            rd_ptr     <= rd_ptr + 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic load(input logic [WIDTH-1:0] w);
        fmem[wr_ptr] = w;
        wr_ptr       = wr_ptr + 8'd1;
        exp_q.push_back(w);
    endtask

    // Called at a negedge with inputs already set; samples before the next posedge.
    task automatic cyc();
        #1;
        s_rden  = rd_en;
        s_valid = m_valid;
        s_data  = m_data;
        if (rd_en) n_rden++;
        chk("rden_while_empty", 32'(rd_en && empty), 32'd0);
        if (m_valid && m_ready && rd_rst) begin
            chk("sb_have_word", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        @(negedge rd_clk);
    endtask

    task automatic do_reset();
        rd_rst = 1'b0;
        repeat (2) @(negedge rd_clk);
        rd_rst = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        // Reset with a word waiting in the FIFO.
        load(16'h1234);
        m_ready = 1'b1;
        @(negedge rd_clk);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("rst_rden", 32'(s_rden), 32'd0);
            chk("rst_valid", 32'(s_valid), 32'd0);
            chk("rst_data", 32'(s_data), 32'd0);
        end
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
        chk("rst_word_cnt", rd_word_cnt, 32'd0);
`endif

        // Single word: rd_en in cycle 0, m_valid in cycle 2 only.
        rd_rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("single_rden", 32'(s_rden), 32'(c == 0));
            chk("single_vld", 32'(s_valid), 32'(c == 2));
            if (c == 2) chk("single_dat", 32'(s_data), 32'h1234);
        end

        // Streaming 8 words at one per cycle.
        do_reset();
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
        chk("word_cnt_after_rst", rd_word_cnt, 32'd0);
`endif
        for (int w = 1; w <= 8; w++) load(16'(w));
        for (int c = 0; c < 12; c++) begin
            cyc();
            chk("stream_rden", 32'(s_rden), 32'(c < 8));
            chk("stream_vld", 32'(s_valid), 32'(c >= 2 && c <= 9));
        end
        chk("stream_sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
        chk("stream_word_cnt", rd_word_cnt, 32'd8);
`endif

        // Backpressure: only BUF_DEPTH reads, head word held stable.
        m_ready = 1'b0;
        for (int w = 1; w <= 8; w++) load(16'(w));
        n_rden = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (c >= 2) chk("bp_hold", 32'({s_valid, s_data}), 32'({1'b1, 16'h0001}));
        end
        chk("bp_reads", 32'(n_rden), 32'd2);
        m_ready = 1'b1;
        for (int c = 0; c < 14; c++) cyc();
        chk("bp_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_idle", 32'(s_valid), 32'd0);

        // FIFO runs empty while the last read is in flight.
        for (int w = 0; w < 3; w++) load(16'h00A1 + 16'(w));
        for (int c = 0; c < 7; c++) begin
            cyc();
            chk("emp_rden", 32'(s_rden), 32'(c < 3));
            chk("emp_vld", 32'(s_valid), 32'(c >= 2 && c <= 4));
        end
        chk("emp_sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset with a full buffer: async clear, nothing stale afterwards.
        m_ready = 1'b0;
        for (int w = 1; w <= 8; w++) load(16'h0B00 + 16'(w));
        for (int c = 0; c < 5; c++) cyc();
        chk("mid_full_vld", 32'(s_valid), 32'd1);
        #2;
        flush_en = 1'b1;
        rd_rst   = 1'b0;
        #1;
        chk("mid_async_vld", 32'(m_valid), 32'd0);
        chk("mid_async_rden", 32'(rd_en), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge rd_clk);
        rd_rst  = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("mid_no_stale", 32'(s_valid), 32'd0);
            chk("mid_no_read", 32'(s_rden), 32'd0);
        end
        flush_en = 1'b0;
        load(16'hA5A5);
        load(16'h5A5A);
        for (int c = 0; c < 6; c++) cyc();
        chk("mid_sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
        chk("mid_word_cnt", rd_word_cnt, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the async FIFO memory, in the rd_clk domain.
- Drives rd_en into the FIFO memory and captures its registered data_out, which is valid 1 cycle after an accepted read.
- Presents a first-word-fall-through valid/ready stream to downstream logic.
- A small prefetch buffer hides the 1-cycle read latency, so one word per cycle is sustained under continuous m_ready.

Parameters:
- WIDTH, 16, data word width; must match the FIFO memory WIDTH.
- BUF_DEPTH, 2, prefetch buffer entries; must be ≥2 for full throughput.

Ports:
- rd_clk  input  1  read-domain clock; the only clock.
- rd_rst  input  1  asynchronous, active-low reset.
- empty  input  1  FIFO empty flag, synchronous to rd_clk.
- fifo_rdata  input  WIDTH  FIFO memory data_out; valid the cycle after rd_en && !empty.
- rd_en  output  1  read request to the FIFO memory and read-pointer logic.
- m_valid  output  1  stream word available.
- m_data  output  WIDTH  stream word, head of the buffer.
- m_ready  input  1  downstream accepts the word when m_valid && m_ready.

Behaviour:
- Reset (rd_rst=0, async):
  - rd_en=0, m_valid=0, m_data=0.
  - count=0, inflight=0.
  - Buffer read and write indices = 0.
- Internal state:
  - count: 0..BUF_DEPTH, number of valid words in the buffer.
  - inflight: 1 bit, set when a read was issued last cycle.
- pop = m_valid && m_ready.
- rd_en = !empty && ((count + inflight − pop) < BUF_DEPTH).
  - Combinational from m_ready and empty.
  - Forced to 0 while rd_rst=0.
- Issue cycle: rd_en=1 with empty=0 sets inflight=1 for the next cycle.
  - rd_en is never asserted while empty=1.
- Capture cycle: inflight=1 → fifo_rdata is written at the buffer write index, and the write index increments modulo BUF_DEPTH.
- Count update each cycle: count_next = count + inflight − pop.
  - Simultaneous capture and pop leaves count unchanged.
  - Implementation must assert count never exceeds BUF_DEPTH and never goes below 0.
- m_valid = (count != 0), registered.
- m_data = buffer[read index], registered with no bubble.
  - Read index increments modulo BUF_DEPTH on pop.
- Latency: a first word written into an empty FIFO appears on m_valid 2 rd_clk cycles after empty falls.
  - Cycle 0: rd_en asserted.
  - Cycle 1: capture.
  - Cycle 2: m_valid=1.
- Throughput: with m_ready held at 1 and the FIFO non-empty, rd_en=1 every cycle and m_valid stays 1 (1 word/cycle).
- Backpressure: with m_ready=0, reads stop once count + inflight = BUF_DEPTH.
  - m_data and m_valid stay stable until accepted.
- Empty boundary:
  - empty rising stops further rd_en.
  - A read already in flight is still captured.
  - Buffered words drain normally.
- Wrap-around: indices are log2(BUF_DEPTH) bits when BUF_DEPTH is a power of two; otherwise they wrap explicitly at BUF_DEPTH−1 → 0.
- Reset mid-operation:
  - Buffered and in-flight words are discarded.
  - rd_rst must be asserted together with the FIFO read-side reset, so read pointers and the buffer stay consistent.
- No word is dropped or duplicated: the delivered sequence equals the FIFO write sequence.

Optional Feature:
- Macro FIFO_RD_STREAM_WORD_CNT_EN.
- Defined:
  - Adds output rd_word_cnt [31:0].
  - Reset to 0; increments on every pop; wraps 0xFFFFFFFF → 0.
  - Excluded from all other logic.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_rd_pkg holds:
  - default BUF_DEPTH constant;
  - function returning the count width, $clog2(BUF_DEPTH+1);
  - index-increment-with-wrap function.
- Sub-module fifo_rd_skid_buf holds:
  - BUF_DEPTH×WIDTH storage;
  - read and write indices;
  - count register.
- fifo_rd_stream keeps only rd_en generation, inflight tracking, and output registers.

Test Plan:
- Reset with empty=0 → rd_en=0, m_valid=0, m_data=0 throughout reset; after release rd_en=1 on the first cycle.
- Single word: FIFO holds 0x1234 and m_ready=1.
  - Expect rd_en for 1 cycle.
  - m_valid=1 with m_data=0x1234 exactly 2 cycles later, for 1 cycle.
  - Then m_valid=0.
- Streaming: 8 words 0x0001..0x0008 pre-loaded, m_ready=1 → after 2-cycle latency m_valid=1 for 8 consecutive cycles, data in order.
- Backpressure: 8 words loaded, m_ready=0 for 10 cycles.
  - Exactly BUF_DEPTH=2 reads issued.
  - m_data holds 0x0001 stably.
  - Releasing m_ready delivers 0x0001..0x0008 in order.
- Empty mid-stream: empty rises while a read is in flight → no further rd_en; the captured word is still delivered; m_valid falls after the buffer drains.
- Reset mid-operation: assert rd_rst with count=2 → m_valid=0 asynchronously; after release no stale word appears.
  - With FIFO_RD_STREAM_WORD_CNT_EN defined, rd_word_cnt=0 after reset and equals 8 after the streaming test.
